ddr_burst_sched: RTL and testbench
==================================

DDR_BURST_SCHED -- requirements
Module: ddr_burst_sched

Interface
REQ-001 Parameter ADDR_WIDTH, default 30, DDR app address width.
REQ-002 Parameter MEM_DATA_BITS, default 256, beat width.
REQ-003 Parameter BURST_LEN, default 64, beats per burst (1..255).
REQ-004 Parameter ADDR_STEP, default 8, app address increment per beat.
REQ-005 Parameter DDR_BEATS, default 16777216, ring depth in beats; integer multiple of BURST_LEN.
REQ-006 Parameter TIMEOUT, default 4096, max cycles from request to finish.
REQ-007 ddr_clk_i  in  1  sole clock; ddr_rst_i  in  1  synchronous active-high reset.
REQ-008 init_done_i  in  1  DDR calibration complete.
REQ-009 in_fifo_cnt_i  in  16  beats held in ingress FWFT FIFO; in_fifo_data_i  in  MEM_DATA_BITS  head word; in_fifo_rd_o  out  1  pop.
REQ-010 out_fifo_free_i  in  16  free beats in egress FIFO; out_fifo_wr_o  out  1  push; out_fifo_data_o  out  MEM_DATA_BITS  push data.
REQ-011 wr_ddr_req_o  out  1; wr_ddr_len_o  out  8; wr_ddr_addr_o  out  ADDR_WIDTH; wr_ddr_data_req_i  in  1; wr_ddr_data_o  out  MEM_DATA_BITS; wr_ddr_finish_i  in  1.
REQ-012 rd_ddr_req_o  out  1; rd_ddr_len_o  out  8; rd_ddr_addr_o  out  ADDR_WIDTH; rd_ddr_data_valid_i  in  1; rd_ddr_data_i  in  MEM_DATA_BITS; rd_ddr_finish_i  in  1.
REQ-013 burst_idle_i  in  1  burst controller idle.
REQ-014 fill_beats_o  out  ADDR_WIDTH  beats resident in DDR; blocked_cnt_o  out  32  cycles ingress-ready but ring full; timeout_err_o  out  1  sticky timeout flag.

Function
REQ-015 States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
REQ-016 wr_ok = in_fifo_cnt_i >= BURST_LEN and fill_beats_o + BURST_LEN <= DDR_BEATS; rd_ok = fill_beats_o >= BURST_LEN and out_fifo_free_i >= BURST_LEN.
REQ-017 IDLE: leave only when init_done_i=1 and burst_idle_i=1; wr_ok alone -> WR_REQ, rd_ok alone -> RD_REQ, both -> direction opposite to last granted (write first after reset).
REQ-018 WR_REQ/RD_REQ last exactly one cycle; wr_ddr_req_o / rd_ddr_req_o =1 only in that state; then WR_WAIT / RD_WAIT.
REQ-019 Length outputs = BURST_LEN constant; address outputs = ptr * ADDR_STEP, held stable from REQ state through WAIT.
REQ-020 wr_ddr_data_o = in_fifo_data_i combinationally; in_fifo_rd_o = wr_ddr_data_req_i in WR_WAIT, else 0.
REQ-021 out_fifo_wr_o = rd_ddr_data_valid_i in RD_WAIT, else 0; out_fifo_data_o = rd_ddr_data_i, zero latency.
REQ-022 WR_WAIT -> IDLE on wr_ddr_finish_i: wr_ptr += BURST_LEN (wrap to 0 at DDR_BEATS), fill += BURST_LEN.
REQ-023 RD_WAIT -> IDLE on rd_ddr_finish_i: rd_ptr += BURST_LEN (wrap), fill -= BURST_LEN.
REQ-024 fill_beats_o never exceeds DDR_BEATS nor underflows 0; both directions never update in one cycle.
REQ-025 Timeout counter clears on REQ entry, counts in WAIT; reaching TIMEOUT -> IDLE, timeout_err_o=1, pointers/fill unchanged.
REQ-026 blocked_cnt_o +1 each cycle in_fifo_cnt_i >= BURST_LEN and fill_beats_o + BURST_LEN > DDR_BEATS; saturates at 2^32-1.
REQ-027 init_done_i low in IDLE: no request issued; low in WAIT: transaction completes normally.
REQ-028 Finish pulses or data strobes outside matching WAIT state are ignored.

Reset
REQ-029 ddr_rst_i=1 at any cycle, incl. mid-burst: next state IDLE, ptrs/fill/blocked_cnt/timeout counter 0, timeout_err_o 0, all req/push/pop outputs 0, last-grant = read.

Verification
REQ-030 in_fifo_cnt_i=64, fill=0, idle: wr_ddr_req_o one pulse, addr 0, len 64; 64 data_req -> 64 pops; finish -> fill=64, next wr addr 512.
REQ-031 fill=64, out_fifo_free_i=64, no ingress: rd_ddr_req_o pulse addr 0; 64 valids -> 64 pushes; finish -> fill=0.
REQ-032 Both eligible continuously: grants alternate W,R,W,R.
REQ-033 DDR_BEATS=128, fill=128, ingress=64 for 10 cycles: no wr_ddr_req_o, blocked_cnt_o=10; wr_ptr wraps to 0 after 2 bursts.
REQ-034 TIMEOUT=16, no finish: IDLE after 16 WAIT cycles, timeout_err_o=1, fill unchanged.
REQ-035 Reset asserted in WR_WAIT after 10 pops: next cycle IDLE, all outputs 0, fill 0.

Source files
------------

// File: rtl/ddr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : ddr_burst_sched
// Description : Schedules fixed-length write and read bursts between an
//               ingress FWFT FIFO, a DDR ring buffer and an egress FIFO.
//               Writes are issued when a full burst is waiting and the ring
//               has room. Reads are issued when a full burst is resident and
//               the egress FIFO can absorb it. When both are possible, the
//               direction alternates. Every transaction is bounded by a
//               timeout.
// Ports       :
//   ddr_clk_i / ddr_rst_i         clock, synchronous active-high reset
//   init_done_i, burst_idle_i     launch qualifiers
//   in_fifo_*                     ingress FIFO level, head word and pop
//   out_fifo_*                    egress FIFO free space, push and data
//   wr_ddr_*                      write burst request and data handshake
//   rd_ddr_*                      read burst request and data handshake
//   fill_beats_o                  beats resident in the DDR ring
//   blocked_cnt_o                 cycles with ingress ready but ring full
//   timeout_err_o                 sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_burst_sched #(
    parameter int ADDR_WIDTH    = 30,
    parameter int MEM_DATA_BITS = 256,
    parameter int BURST_LEN     = 64,
    parameter int ADDR_STEP     = 8,
    parameter int DDR_BEATS     = 16777216,
    parameter int TIMEOUT       = 4096
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_i,
    input  logic                     init_done_i,
    input  logic [15:0]              in_fifo_cnt_i,
    input  logic [MEM_DATA_BITS-1:0] in_fifo_data_i,
    output logic                     in_fifo_rd_o,
    input  logic [15:0]              out_fifo_free_i,
    output logic                     out_fifo_wr_o,
    output logic [MEM_DATA_BITS-1:0] out_fifo_data_o,
    output logic                     wr_ddr_req_o,
    output logic [7:0]               wr_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
    input  logic                     wr_ddr_data_req_i,
    output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
    input  logic                     wr_ddr_finish_i,
    output logic                     rd_ddr_req_o,
    output logic [7:0]               rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
    input  logic                     rd_ddr_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
    input  logic                     rd_ddr_finish_i,
    input  logic                     burst_idle_i,
    output logic [ADDR_WIDTH-1:0]    fill_beats_o,
    output logic [31:0]              blocked_cnt_o,
    output logic                     timeout_err_o
);

    // Two guard bits so fill + BURST_LEN can never wrap before it is compared.
    localparam int c_cw = ADDR_WIDTH + 2;
    localparam int c_tw = $clog2(TIMEOUT + 1);

    localparam logic [c_cw-1:0]       c_burst_ext  = c_cw'(BURST_LEN);
    localparam logic [c_cw-1:0]       c_beats_ext  = c_cw'(DDR_BEATS);
    localparam logic [ADDR_WIDTH-1:0] c_burst_fill = ADDR_WIDTH'(BURST_LEN);
    localparam logic [15:0]           c_burst_cnt  = 16'(BURST_LEN);
    localparam logic [7:0]            c_len        = 8'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] c_step       = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [c_tw-1:0]       c_to_last    = c_tw'(TIMEOUT - 1);
    localparam logic [c_tw-1:0]       c_to_one     = c_tw'(1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wr_req  = 3'd1;
    localparam logic [2:0] c_st_wr_wait = 3'd2;
    localparam logic [2:0] c_st_rd_req  = 3'd3;
    localparam logic [2:0] c_st_rd_wait = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_fill;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_wr_req;
    logic                  r_rd_req;
    logic                  r_last_wr;
    logic [c_tw-1:0]       r_to;
    logic [31:0]           r_blocked;
    logic                  r_timeout_err;

    logic [c_cw-1:0]       w_fill_ext;
    logic [c_cw-1:0]       w_fill_plus_ext;
    logic                  w_ingress_ready;
    logic                  w_room;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_blocked;
    logic                  w_pick_wr;
    logic                  w_pick_rd;
    logic [c_cw-1:0]       w_wr_ptr_sum;
    logic [c_cw-1:0]       w_rd_ptr_sum;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;

    assign w_fill_ext      = {2'b00, r_fill};
    assign w_fill_plus_ext = w_fill_ext + c_burst_ext;
    assign w_ingress_ready = (in_fifo_cnt_i >= c_burst_cnt);
    assign w_room          = (w_fill_plus_ext <= c_beats_ext);
    assign w_wr_ok         = w_ingress_ready & w_room;
    assign w_rd_ok         = (w_fill_ext >= c_burst_ext) & (out_fifo_free_i >= c_burst_cnt);
    assign w_blocked       = w_ingress_ready & ~w_room;

    // Tie-break: a contested grant goes to the direction not served last.
    assign w_pick_wr = w_wr_ok & (~w_rd_ok | ~r_last_wr);
    assign w_pick_rd = w_rd_ok & ~w_pick_wr;

    // Ring depth is a whole number of bursts, so the pointer lands exactly on
    // DDR_BEATS when it has to wrap.
    assign w_wr_ptr_sum = {2'b00, r_wr_ptr} + c_burst_ext;
    assign w_rd_ptr_sum = {2'b00, r_rd_ptr} + c_burst_ext;
    assign w_wr_ptr_nxt = (w_wr_ptr_sum >= c_beats_ext) ? '0 : w_wr_ptr_sum[ADDR_WIDTH-1:0];
    assign w_rd_ptr_nxt = (w_rd_ptr_sum >= c_beats_ext) ? '0 : w_rd_ptr_sum[ADDR_WIDTH-1:0];

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i) begin
            r_state       <= c_st_idle;
            r_fill        <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_wr_req      <= 1'b0;
            r_rd_req      <= 1'b0;
            r_last_wr     <= 1'b0;
            r_to          <= '0;
            r_blocked     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;

            if (w_blocked && (r_blocked != 32'hFFFF_FFFF)) begin
                r_blocked <= r_blocked + 32'd1;
            end

            case (r_state)
                c_st_idle: begin
                    if (init_done_i && burst_idle_i) begin
                        if (w_pick_wr) begin
                            r_state   <= c_st_wr_req;
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= r_wr_ptr * c_step;
                            r_last_wr <= 1'b1;
                            r_to      <= '0;
                        end else if (w_pick_rd) begin
                            r_state   <= c_st_rd_req;
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= r_rd_ptr * c_step;
                            r_last_wr <= 1'b0;
                            r_to      <= '0;
                        end
                    end
                end

                c_st_wr_req: begin
                    r_state <= c_st_wr_wait;
                end

                c_st_wr_wait: begin
                    if (wr_ddr_finish_i) begin
                        r_state  <= c_st_idle;
                        r_wr_ptr <= w_wr_ptr_nxt;
                        r_fill   <= r_fill + c_burst_fill;
                    end else if (r_to == c_to_last) begin
                        // Abandon the burst; ring bookkeeping stays untouched.
                        r_state       <= c_st_idle;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to <= r_to + c_to_one;
                    end
                end

                c_st_rd_req: begin
                    r_state <= c_st_rd_wait;
                end

                c_st_rd_wait: begin
                    if (rd_ddr_finish_i) begin
                        r_state  <= c_st_idle;
                        r_rd_ptr <= w_rd_ptr_nxt;
                        r_fill   <= r_fill - c_burst_fill;
                    end else if (r_to == c_to_last) begin
                        r_state       <= c_st_idle;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to <= r_to + c_to_one;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign wr_ddr_req_o    = r_wr_req;
    assign wr_ddr_len_o    = c_len;
    assign wr_ddr_addr_o   = r_wr_addr;
    assign wr_ddr_data_o   = in_fifo_data_i;
    assign in_fifo_rd_o    = (r_state == c_st_wr_wait) & wr_ddr_data_req_i;

    assign rd_ddr_req_o    = r_rd_req;
    assign rd_ddr_len_o    = c_len;
    assign rd_ddr_addr_o   = r_rd_addr;
    assign out_fifo_wr_o   = (r_state == c_st_rd_wait) & rd_ddr_data_valid_i;
    assign out_fifo_data_o = rd_ddr_data_i;

    assign fill_beats_o    = r_fill;
    assign blocked_cnt_o   = r_blocked;
    assign timeout_err_o   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_burst_sched
// Description : Directed bench for ddr_burst_sched. A transaction-level model
//               predicts every output each cycle; literal expectations pin
//               addresses, beat counts, fill levels and the timeout case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_burst_sched;

    localparam int BL      = 64;
    localparam int STEP    = 8;
    localparam int DB      = 128;
    localparam int TO_MAIN = 4096;
    localparam int TO_FAST = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_done, burst_idle;
    logic [15:0]  in_cnt, out_free;
    logic [255:0] in_data, rd_data;
    logic         wr_data_req, wr_finish, rd_valid, rd_finish;

    logic         in_rd, out_wr, wr_req, rd_req, terr;
    logic [255:0] out_data, wr_data;
    logic [7:0]   wr_len, rd_len;
    logic [29:0]  wr_addr, rd_addr, fill;
    logic [31:0]  blocked;

    logic         t_in_rd, t_out_wr, t_wr_req, t_rd_req, t_terr;
    logic [255:0] t_out_data, t_wr_data;
    logic [7:0]   t_wr_len, t_rd_len;
    logic [29:0]  t_wr_addr, t_rd_addr, t_fill;
    logic [31:0]  t_blocked;

    always #5 clk = ~clk;

    ddr_burst_sched #(.BURST_LEN(BL), .ADDR_STEP(STEP), .DDR_BEATS(DB), .TIMEOUT(TO_MAIN)) dut (
        .ddr_clk_i(clk), .ddr_rst_i(rst), .init_done_i(init_done),
        .in_fifo_cnt_i(in_cnt), .in_fifo_data_i(in_data), .in_fifo_rd_o(in_rd),
        .out_fifo_free_i(out_free), .out_fifo_wr_o(out_wr), .out_fifo_data_o(out_data),
        .wr_ddr_req_o(wr_req), .wr_ddr_len_o(wr_len), .wr_ddr_addr_o(wr_addr),
        .wr_ddr_data_req_i(wr_data_req), .wr_ddr_data_o(wr_data), .wr_ddr_finish_i(wr_finish),
        .rd_ddr_req_o(rd_req), .rd_ddr_len_o(rd_len), .rd_ddr_addr_o(rd_addr),
        .rd_ddr_data_valid_i(rd_valid), .rd_ddr_data_i(rd_data), .rd_ddr_finish_i(rd_finish),
        .burst_idle_i(burst_idle), .fill_beats_o(fill), .blocked_cnt_o(blocked),
        .timeout_err_o(terr)
    );

    ddr_burst_sched #(.BURST_LEN(BL), .ADDR_STEP(STEP), .DDR_BEATS(DB), .TIMEOUT(TO_FAST)) dut_to (
        .ddr_clk_i(clk), .ddr_rst_i(rst), .init_done_i(init_done),
        .in_fifo_cnt_i(in_cnt), .in_fifo_data_i(in_data), .in_fifo_rd_o(t_in_rd),
        .out_fifo_free_i(out_free), .out_fifo_wr_o(t_out_wr), .out_fifo_data_o(t_out_data),
        .wr_ddr_req_o(t_wr_req), .wr_ddr_len_o(t_wr_len), .wr_ddr_addr_o(t_wr_addr),
        .wr_ddr_data_req_i(wr_data_req), .wr_ddr_data_o(t_wr_data), .wr_ddr_finish_i(wr_finish),
        .rd_ddr_req_o(t_rd_req), .rd_ddr_len_o(t_rd_len), .rd_ddr_addr_o(t_rd_addr),
        .rd_ddr_data_valid_i(rd_valid), .rd_ddr_data_i(rd_data), .rd_ddr_finish_i(rd_finish),
        .burst_idle_i(burst_idle), .fill_beats_o(t_fill), .blocked_cnt_o(t_blocked),
        .timeout_err_o(t_terr)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int pop_cnt = 0, push_cnt = 0, wreq_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk) begin
        #2;
        in_data = rnd256();
        rd_data = rnd256();
    end

    // Transaction-level model: m_txn is the burst in flight (0 none, 1 write,
    // 2 read), m_age counts cycles since its grant (0 = request cycle).
    int      m_fill = 0, m_wptr = 0, m_rptr = 0, m_txn = 0, m_age = 0;
    longint  m_blocked = 0;
    bit      m_err = 1'b0, m_prefer_wr = 1'b1;

    always @(posedge clk) begin
        bit wok, rok;
        if (rst) begin
            m_fill = 0; m_wptr = 0; m_rptr = 0; m_txn = 0; m_age = 0;
            m_blocked = 0; m_err = 1'b0; m_prefer_wr = 1'b1;
        end else begin
            if (in_cnt >= BL && m_fill + BL > DB && m_blocked < 64'hFFFF_FFFF) m_blocked++;
            if (m_txn == 0) begin
                if (init_done && burst_idle) begin
                    wok = (in_cnt >= BL) && (m_fill + BL <= DB);
                    rok = (m_fill >= BL) && (out_free >= BL);
                    if (wok && (!rok || m_prefer_wr)) begin
                        m_txn = 1; m_age = 0; m_prefer_wr = 1'b0;
                    end else if (rok) begin
                        m_txn = 2; m_age = 0; m_prefer_wr = 1'b1;
                    end
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (m_txn == 1 && wr_finish) begin
                m_wptr = (m_wptr + BL) % DB; m_fill += BL; m_txn = 0;
            end else if (m_txn == 2 && rd_finish) begin
                m_rptr = (m_rptr + BL) % DB; m_fill -= BL; m_txn = 0;
            end else if (m_age == TO_MAIN) begin
                m_err = 1'b1; m_txn = 0;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_req", wr_req, (m_txn == 1 && m_age == 0));
            chk("rd_req", rd_req, (m_txn == 2 && m_age == 0));
            chk("pop", in_rd, (m_txn == 1 && m_age > 0 && wr_data_req));
            chk("push", out_wr, (m_txn == 2 && m_age > 0 && rd_valid));
            chk("wr_len", wr_len, BL);
            chk("rd_len", rd_len, BL);
            if (m_txn == 1) chk("wr_addr", wr_addr, m_wptr * STEP);
            if (m_txn == 2) chk("rd_addr", rd_addr, m_rptr * STEP);
            chk("wr_data", wr_data, in_data);
            chk("out_data", out_data, rd_data);
            chk("fill", fill, m_fill);
            chk("blocked", blocked, m_blocked);
            chk("timeout_err", terr, m_err);
            if (in_rd)  pop_cnt++;
            if (out_wr) push_cnt++;
            if (wr_req) wreq_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 for a write grant, 2 for a read grant, 0 if none in budget.
    task automatic wait_req(output int dir);
        int i;
        dir = 0;
        i = 0;
        while (dir == 0 && i < 200) begin
            @(negedge clk);
            if (wr_req) dir = 1;
            else if (rd_req) dir = 2;
            i++;
        end
    endtask

    task automatic burst(input int dir_exp, input int n, input int addr_exp,
                         input bit fin, input bit drop_init);
        int dir;
        wait_req(dir);
        chk("grant_dir", dir, dir_exp);
        if (dir != 0) begin
            chk("req_addr", (dir == 1) ? wr_addr : rd_addr, addr_exp);
            chk("req_len", (dir == 1) ? wr_len : rd_len, BL);
            tick();
            if (drop_init) init_done = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (dir == 1) wr_data_req = 1'b1; else rd_valid = 1'b1;
                tick();
            end
            wr_data_req = 1'b0;
            rd_valid    = 1'b0;
            if (fin) begin
                if (dir == 1) wr_finish = 1'b1; else rd_finish = 1'b1;
                tick();
                wr_finish = 1'b0;
                rd_finish = 1'b0;
            end
            init_done = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst = 1'b1; init_done = 1'b0; burst_idle = 1'b1;
        in_cnt = 16'd0; out_free = 16'd0;
        wr_data_req = 1'b0; wr_finish = 1'b0; rd_valid = 1'b0; rd_finish = 1'b0;
        in_data = '0; rd_data = '0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_fill", fill, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_terr", terr, 0);
        chk("rst_reqs", {wr_req, rd_req, in_rd, out_wr}, 0);
        tick();
        rst = 1'b0;

        // Launch qualifiers hold off a ready write.
        in_cnt = 16'd64;
        repeat (5) tick();
        init_done = 1'b1; burst_idle = 1'b0;
        repeat (3) tick();
        chk("no_req_unqualified", wreq_cnt, 0);
        burst_idle = 1'b1;

        // First write burst.
        pop_cnt = 0;
        burst(1, 64, 0, 1'b1, 1'b0);
        in_cnt = 16'd0;
        @(negedge clk);
        chk("wr1_pops", pop_cnt, 64);
        chk("wr1_fill", fill, 64);

        // First read burst with init_done dropped mid-transaction.
        out_free = 16'd64;
        push_cnt = 0;
        burst(2, 64, 0, 1'b1, 1'b1);
        out_free = 16'd0;
        @(negedge clk);
        chk("rd1_pushes", push_cnt, 64);
        chk("rd1_fill", fill, 0);

        // Strobes and finishes outside a transaction change nothing.
        pop_cnt = 0; push_cnt = 0;
        wr_finish = 1'b1; rd_finish = 1'b1; wr_data_req = 1'b1; rd_valid = 1'b1;
        repeat (4) tick();
        wr_finish = 1'b0; rd_finish = 1'b0; wr_data_req = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        chk("stray_fill", fill, 0);
        chk("stray_beats", pop_cnt + push_cnt, 0);

        // Both sides eligible: W, R, W, R with wrapping addresses.
        in_cnt = 16'd64; out_free = 16'd64;
        burst(1, 64, 512, 1'b1, 1'b0);
        burst(2, 64, 512, 1'b1, 1'b0);
        burst(1, 64, 0, 1'b1, 1'b0);
        burst(2, 64, 0, 1'b1, 1'b0);
        in_cnt = 16'd0; out_free = 16'd0;
        @(negedge clk);
        chk("alt_fill", fill, 0);

        // Fill the ring, then hold ingress ready for 10 cycles.
        in_cnt = 16'd64;
        burst(1, 64, 512, 1'b1, 1'b0);
        burst(1, 64, 0, 1'b1, 1'b0);
        in_cnt = 16'd0;
        wreq_cnt = 0;
        in_cnt = 16'd64;
        repeat (10) tick();
        in_cnt = 16'd0;
        @(negedge clk);
        chk("full_blocked", blocked, 10);
        chk("full_no_req", wreq_cnt, 0);
        chk("full_fill", fill, 128);

        // Make room, then reset in the middle of a write after 10 pops.
        out_free = 16'd64;
        burst(2, 64, 512, 1'b1, 1'b0);
        out_free = 16'd0;
        in_cnt = 16'd64;
        pop_cnt = 0;
        burst(1, 10, 512, 1'b0, 1'b0);
        chk("rst_mid_pops", pop_cnt, 10);
        rst = 1'b1; in_cnt = 16'd0;
        tick();
        rst = 1'b0; wr_data_req = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {wr_req, rd_req, in_rd, out_wr, terr}, 0);
        chk("rst_mid_fill", fill, 0);
        chk("rst_mid_blocked", blocked, 0);
        tick();
        wr_data_req = 1'b0;

        // Short-timeout instance: 16 waiting cycles, then back to idle.
        in_cnt = 16'd64; wr_data_req = 1'b1;
        c = 0;
        while (!t_wr_req && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("to_req_seen", t_wr_req, 1);
        chk("to_req_addr", t_wr_addr, 0);
        chk("to_req_len", t_wr_len, 64);
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!t_in_rd) break;
            c++;
        end
        chk("to_wait_cycles", c, 16);
        chk("to_err", t_terr, 1);
        chk("to_fill", t_fill, 0);
        chk("to_side", {t_wr_req, t_rd_req, t_out_wr, t_rd_addr, t_rd_len, t_blocked}, {3'b000, 30'd0, 8'd64, 32'd0});
        chk("to_data", {t_wr_data, t_out_data} == {in_data, rd_data}, 1);
        tick();
        wr_data_req = 1'b0; in_cnt = 16'd0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
